struct_bit_tx: RTL and testbench

Serial frame transmitter: it is the transmit-side counterpart of the struct-based single-bit capture/registering blocks in the synth test set. It accepts a parallel word over a valid/ready handshake and holds it in an internal struct-typed state register. It then drives the word onto a one-bit serial output as a framed bit stream, LSB first. It sits between a parallel producer and any single-bit registered receiver in the same clock domain.

---
 rtl/struct_bit_tx.sv | 109 ++++++++++
 tb/tb_struct_bit_tx.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/struct_bit_tx.sv
// Framed serial transmitter: start(1), payload LSB first, [parity], stop(0).
// Define STRUCT_BIT_TX_PARITY_EN to insert an even-parity bit before stop.
module struct_bit_tx #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out,
    output logic              out_valid,
    output logic              busy
);

    localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
`ifdef STRUCT_BIT_TX_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd3;
`endif
    localparam logic [2:0] S_STOP   = 3'd4;

    typedef struct packed {
        logic [2:0]        state;
        logic [DATA_W-1:0] shift;
        logic [CW-1:0]     count;
`ifdef STRUCT_BIT_TX_PARITY_EN
        logic              par;
`endif
    } tx_t;

    tx_t r;
    tx_t nx;
    tx_t ld;
    logic xfer;

    assign in_ready = (r.state == S_IDLE) || (r.state == S_STOP);
    assign xfer     = in_valid && in_ready;

    always_comb begin
        ld       = '0;
        ld.state = S_START;
        ld.shift = in_data;
`ifdef STRUCT_BIT_TX_PARITY_EN
        ld.par   = ^in_data;
`endif
    end

    always_comb begin
        nx = r;
        unique case (r.state)
            S_IDLE: begin
                if (xfer) nx = ld;
            end
            S_START: begin
                nx.state = S_DATA;
            end
            S_DATA: begin
                nx.shift = r.shift >> 1;
                nx.count = r.count + 1'b1;
                if (r.count == LAST) begin
`ifdef STRUCT_BIT_TX_PARITY_EN
                    nx.state = S_PARITY;
`else
                    nx.state = S_STOP;
`endif
                end
            end
`ifdef STRUCT_BIT_TX_PARITY_EN
            S_PARITY: begin
                nx.state = S_STOP;
            end
`endif
            S_STOP: begin
                // A word offered during stop starts the next frame with no gap
                if (xfer) nx = ld;
                else      nx.state = S_IDLE;
            end
            default: begin
                nx = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r <= '0;
        else          r <= nx;
    end

    always_comb begin
        out = 1'b0;
        unique case (r.state)
            S_START:  out = 1'b1;
            S_DATA:   out = r.shift[0];
`ifdef STRUCT_BIT_TX_PARITY_EN
            S_PARITY: out = r.par;
`endif
            default:  out = 1'b0;
        endcase
    end

    assign out_valid = (r.state != S_IDLE);
    assign busy      = out_valid;

endmodule

// File: tb/tb_struct_bit_tx.sv
// Bench for struct_bit_tx: vector table, corner sequences and random
// traffic checked against a queue-of-expected-line-bits model.
module tb_struct_bit_tx;

    localparam int W = 8;
`ifdef STRUCT_BIT_TX_PARITY_EN
    localparam int L   = W + 3;
    localparam bit PAR = 1'b1;
`else
    localparam int L   = W + 2;
    localparam bit PAR = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         in_valid = 1'b0;
    logic [W-1:0] in_data = '0;
    logic         in_ready;
    logic         out;
    logic         out_valid;
    logic         busy;

    always #5 clk = ~clk;

    struct_bit_tx #(.DATA_W(W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out       (out),
        .out_valid (out_valid),
        .busy      (busy)
    );

    typedef struct {
        logic [W-1:0] data;
        logic [10:0]  frame;
    } vec_t;

    int   total = 0;
    int   bad = 0;
    int   acc = 0;
    bit   q[$];
    logic seen;
    logic seen_ov;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    // Line model: q holds the bits still to appear, q[0] is shown now
    task automatic check_now();
        logic eb;
        logic ev;
        ev = (q.size() > 0);
        eb = ev ? q[0] : 1'b0;
        chk("out", {31'd0, out}, {31'd0, eb});
        chk("out_valid", {31'd0, out_valid}, {31'd0, ev});
        chk("busy", {31'd0, busy}, {31'd0, ev});
        chk("in_ready", {31'd0, in_ready}, {31'd0, q.size() <= 1});
        seen    = out;
        seen_ov = out_valid;
    endtask

    task automatic push_frame(input logic [W-1:0] d);
        q.push_back(1'b1);
        for (int i = 0; i < W; i++) q.push_back(d[i]);
        if (PAR) q.push_back(^d);
        q.push_back(1'b0);
    endtask

    task automatic cyc(input logic v, input logic [W-1:0] d);
        logic x;
        in_valid = v;
        in_data  = d;
        #1;
        check_now();
        x = v && reset_n && (q.size() <= 1);
        @(posedge clk);
        if (!reset_n) begin
            q.delete();
        end else begin
            if (q.size() > 0) q.delete(0);
            if (x) begin
                push_frame(d);
                acc++;
            end
        end
        @(negedge clk);
    endtask

    vec_t tbl[4];
    int a0;
    int run;
    int maxrun;
    logic [W-1:0] pend;

    initial begin
`ifdef STRUCT_BIT_TX_PARITY_EN
        tbl[0] = '{8'hA5, 11'b00101001011};
        tbl[1] = '{8'h07, 11'b01000001111};
        tbl[2] = '{8'h3C, 11'b00001111001};
        tbl[3] = '{8'hFF, 11'b00111111111};
`else
        tbl[0] = '{8'hA5, 11'b00101001011};
        tbl[1] = '{8'h07, 11'b00000001111};
        tbl[2] = '{8'h3C, 11'b00001111001};
        tbl[3] = '{8'hFF, 11'b00111111111};
`endif

        // Reset held with a word offered: nothing may start
        @(negedge clk);
        for (int i = 0; i < 3; i++) cyc(1'b1, 8'h55);
        chk("reset accepted", acc, 0);
        reset_n = 1'b1;
        cyc(1'b0, '0);

        foreach (tbl[k]) begin
            cyc(1'b1, tbl[k].data);
            for (int i = 0; i < L; i++) begin
                cyc(1'b0, '0);
                chk($sformatf("frame %0h bit%0d", tbl[k].data, i),
                    {31'd0, seen}, {31'd0, tbl[k].frame[i]});
            end
            cyc(1'b0, '0);
            chk("post frame out_valid", {31'd0, seen_ov}, 32'd0);
        end

        // Back-to-back 0x01 then 0x80 with in_valid held high
        a0 = acc;
        run = 0;
        maxrun = 0;
        for (int k = 0; k < 3 * L; k++) begin
            cyc(acc < a0 + 2, (acc == a0) ? 8'h01 : 8'h80);
            run = seen_ov ? run + 1 : 0;
            if (run > maxrun) maxrun = run;
        end
        chk("b2b accepted", acc - a0, 2);
        chk("b2b gapless run", maxrun, 2 * L);

        // Backpressure: 0xFF offered during data bits is ignored
        a0 = acc;
        cyc(1'b1, 8'h01);
        cyc(1'b0, '0);
        for (int i = 0; i < 3; i++) cyc(1'b1, 8'hFF);
        for (int i = 0; i < L; i++) cyc(1'b0, '0);
        chk("backpressure accepted", acc - a0, 1);

        // Reset during data bit 4 of 0x3C
        cyc(1'b1, 8'h3C);
        for (int i = 0; i < 5; i++) cyc(1'b0, '0);
        #1;
        chk("pre-reset data bit4", {31'd0, out}, 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async rst out", {31'd0, out}, 32'd0);
        chk("async rst out_valid", {31'd0, out_valid}, 32'd0);
        chk("async rst in_ready", {31'd0, in_ready}, 32'd1);
        q.delete();
        @(negedge clk);
        cyc(1'b0, '0);
        reset_n = 1'b1;
        cyc(1'b1, 8'h3C);
        for (int i = 0; i < L; i++) begin
            cyc(1'b0, '0);
            chk($sformatf("after rst bit%0d", i),
                {31'd0, seen}, {31'd0, tbl[2].frame[i]});
        end
        cyc(1'b0, '0);

        // Random traffic; data held until its handshake
        pend = 8'($urandom);
        for (int k = 0; k < 400; k++) begin
            a0 = acc;
            cyc(($urandom % 3) == 0, pend);
            if (acc != a0) pend = 8'($urandom);
        end
        for (int i = 0; i < L + 2; i++) cyc(1'b0, '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
